slot_rom_ctrl: RTL and testbench

Apple II slot-side controller directly upstream of the combinational 4KB boot ROM. It synchronises the asynchronous bus strobes and tracks the $C800 expansion-ROM ownership flag. It presents a registered, glitch-free 12-bit ROM address that is held stable for the whole access, and sequences the card's data-bus drive enable. Because the ROM read is purely combinational, this block is the only place address timing is controlled.

---
 rtl/slot_rom_ctrl_pkg.sv | 28 ++
 rtl/slot_rom_ctrl_sync2.sv | 24 ++
 rtl/slot_rom_ctrl.sv | 99 +++++++++
 tb/tb_slot_rom_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/slot_rom_ctrl_pkg.sv
// slot_rom_ctrl shared types and constants.
// FSM states, bus address map and ROM address mapping.
package slot_rom_ctrl_pkg;

  localparam int ROM_AW = 12;

  localparam logic [15:0] EXP_BASE      = 16'hC800;
  localparam logic [15:0] EXP_CLR_DEF   = 16'hCFFF;
  localparam logic [7:0]  SEL_PAGE_MASK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    ACTIVE
  } state_t;

  // $Cn page -> ROM $0xx, $C800-$CFFF -> ROM $000-$7FF
  function automatic logic [ROM_AW-1:0] map_addr(
    input logic        is_sel,
    input logic [10:0] a
  );
    if (is_sel)
      return {4'h0, a[7:0] & SEL_PAGE_MASK};
    return {1'b0, a[10:0]};
  endfunction

endpackage

// File: rtl/slot_rom_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous bus strobes.
// Reset value is a parameter so inactive levels come out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/slot_rom_ctrl.sv
// Apple II slot controller in front of the combinational boot ROM.
// Syncs strobes, holds a registered ROM address, owns the $C800 flag.
module slot_rom_ctrl
  import slot_rom_ctrl_pkg::*;
#(
  parameter int unsigned  SETTLE_CYC   = 1,
  parameter logic [15:0]  EXP_CLR_ADDR = EXP_CLR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       bus_addr,
  input  logic              nI_O_SELECT,
  input  logic              nI_O_STROBE,
  input  logic              R_nW,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              data_oe,
  output logic              expansion_active,
  output logic              rom_fetch
);

  logic   sel_s;
  logic   stb_s;
  logic   rd_s;
  state_t state;
  state_t state_nx;
  logic [2:0] cnt;
  logic   cnt_done;
  logic   clr_hit;
  logic   sel_req;
  logic   stb_req;
  logic   idle_bus;
  logic   cap_drive;

  sync2 #(.RST_VAL(1'b1)) u_sel (
    .clk(clk), .rst_n(rst_n), .d(nI_O_SELECT), .q(sel_s)
  );
  sync2 #(.RST_VAL(1'b1)) u_stb (
    .clk(clk), .rst_n(rst_n), .d(nI_O_STROBE), .q(stb_s)
  );
  sync2 #(.RST_VAL(1'b1)) u_rd (
    .clk(clk), .rst_n(rst_n), .d(R_nW), .q(rd_s)
  );

  assign clr_hit   = (bus_addr == EXP_CLR_ADDR);
  assign sel_req   = !sel_s;
  // a non-owner still tracks $CFFF so the flag can drop
  assign stb_req   = !stb_s && (expansion_active || clr_hit);
  assign idle_bus  = sel_s && stb_s;
  assign cnt_done  = (cnt == 3'(SETTLE_CYC - 1));
  assign cap_drive = rd_s && (sel_req || expansion_active);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (sel_req || stb_req)
          state_nx = SETTLE;
      SETTLE:
        if (idle_bus)
          state_nx = IDLE;
        else if (cnt_done)
          state_nx = CAPTURE;
      CAPTURE:
        state_nx = ACTIVE;
      ACTIVE:
        if (idle_bus)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= 3'd0;
      rom_addr         <= '0;
      data_oe          <= 1'b0;
      expansion_active <= 1'b0;
      rom_fetch        <= 1'b0;
    end else begin
      state     <= state_nx;
      rom_fetch <= 1'b0;
      cnt       <= (state == SETTLE) ? cnt + 3'd1 : 3'd0;
      if (state == CAPTURE) begin
        rom_addr  <= map_addr(sel_req, bus_addr[10:0]);
        data_oe   <= cap_drive;
        rom_fetch <= cap_drive;
        if (sel_req)
          expansion_active <= 1'b1;
        else if (clr_hit)
          expansion_active <= 1'b0;
      end else if (state == ACTIVE && state_nx == IDLE) begin
        data_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slot_rom_ctrl.sv
// Directed self-checking bench for slot_rom_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_slot_rom_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus_addr;
  logic        nI_O_SELECT;
  logic        nI_O_STROBE;
  logic        R_nW;
  logic [11:0] rom_addr;
  logic        data_oe;
  logic        expansion_active;
  logic        rom_fetch;

  int n_cmp = 0;
  int n_err = 0;

  slot_rom_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_addr(bus_addr),
    .nI_O_SELECT(nI_O_SELECT),
    .nI_O_STROBE(nI_O_STROBE),
    .R_nW(R_nW),
    .rom_addr(rom_addr),
    .data_oe(data_oe),
    .expansion_active(expansion_active),
    .rom_fetch(rom_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] a,
                       input logic is_sel,
                       input logic rd);
    bus_addr = a;
    R_nW     = rd;
    if (is_sel)
      nI_O_SELECT = 1'b0;
    else
      nI_O_STROBE = 1'b0;
  endtask

  task automatic release_all();
    nI_O_SELECT = 1'b1;
    nI_O_STROBE = 1'b1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_addr    = 16'h0000;
    nI_O_SELECT = 1'b1;
    nI_O_STROBE = 1'b1;
    R_nW        = 1'b1;
    tick(2);
    chk("rst_addr",  16'(rom_addr), 16'h000);
    chk("rst_oe",    16'(data_oe), 16'h0);
    chk("rst_exp",   16'(expansion_active), 16'h0);
    chk("rst_fetch", 16'(rom_fetch), 16'h0);
    rst_n = 1'b1;
    tick(2);

    // select read $C4A5: data_oe after 5 clocks
    start(16'hC4A5, 1'b1, 1'b1);
    tick(4);
    chk("sel_oe_early", 16'(data_oe), 16'h0);
    tick(1);
    chk("sel_oe",    16'(data_oe), 16'h1);
    chk("sel_fetch", 16'(rom_fetch), 16'h1);
    chk("sel_addr",  16'(rom_addr), 16'h0A5);
    chk("sel_exp",   16'(expansion_active), 16'h1);
    tick(1);
    chk("sel_fetch_one", 16'(rom_fetch), 16'h0);
    chk("sel_oe_hold",   16'(data_oe), 16'h1);
    release_all();
    tick(2);
    chk("rel_oe_2", 16'(data_oe), 16'h1);
    tick(1);
    chk("rel_oe_3", 16'(data_oe), 16'h0);
    tick(2);

    // strobe read with no owner
    reset_pulse();
    start(16'hC9F0, 1'b0, 1'b1);
    tick(6);
    chk("stb_noown_oe",   16'(data_oe), 16'h0);
    chk("stb_noown_exp",  16'(expansion_active), 16'h0);
    chk("stb_noown_addr", 16'(rom_addr), 16'h000);
    release_all();
    tick(3);
    start(16'hC400, 1'b1, 1'b1);
    tick(5);
    chk("own_exp", 16'(expansion_active), 16'h1);
    release_all();
    tick(4);
    start(16'hC9F0, 1'b0, 1'b1);
    tick(5);
    chk("stb_own_addr",  16'(rom_addr), 16'h1F0);
    chk("stb_own_oe",    16'(data_oe), 16'h1);
    chk("stb_own_fetch", 16'(rom_fetch), 16'h1);
    release_all();
    tick(4);

    // owner reads $CFFF, then loses ownership
    start(16'hCFFF, 1'b0, 1'b1);
    tick(5);
    chk("cfff_oe",   16'(data_oe), 16'h1);
    chk("cfff_addr", 16'(rom_addr), 16'h7FF);
    chk("cfff_exp",  16'(expansion_active), 16'h0);
    release_all();
    tick(4);
    start(16'hC900, 1'b0, 1'b1);
    tick(6);
    chk("c900_oe",   16'(data_oe), 16'h0);
    chk("c900_addr", 16'(rom_addr), 16'h7FF);
    release_all();
    tick(3);

    // writes: $CFFF as non-owner, then select write
    start(16'hCFFF, 1'b0, 1'b0);
    tick(5);
    chk("wr_cfff_oe",    16'(data_oe), 16'h0);
    chk("wr_cfff_fetch", 16'(rom_fetch), 16'h0);
    chk("wr_cfff_exp",   16'(expansion_active), 16'h0);
    chk("wr_cfff_addr",  16'(rom_addr), 16'h7FF);
    release_all();
    tick(4);
    start(16'hC400, 1'b1, 1'b0);
    tick(5);
    chk("wr_sel_exp",  16'(expansion_active), 16'h1);
    chk("wr_sel_oe",   16'(data_oe), 16'h0);
    chk("wr_sel_addr", 16'(rom_addr), 16'h000);
    release_all();
    R_nW = 1'b1;
    tick(4);

    // runt select pulse dropped during SETTLE
    start(16'hC4EE, 1'b1, 1'b1);
    tick(1);
    release_all();
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("runt_oe",    16'(data_oe), 16'h0);
      chk("runt_fetch", 16'(rom_fetch), 16'h0);
    end
    chk("runt_addr", 16'(rom_addr), 16'h000);
    chk("runt_exp",  16'(expansion_active), 16'h1);

    // address churn during SETTLE, capture sees stable value
    start(16'hC412, 1'b1, 1'b1);
    tick(1);
    bus_addr = 16'hC455;
    tick(1);
    bus_addr = 16'hC4AA;
    tick(1);
    bus_addr = 16'hC47E;
    tick(1);
    bus_addr = 16'hC4C3;
    tick(1);
    chk("churn_addr", 16'(rom_addr), 16'h0C3);
    chk("churn_oe",   16'(data_oe), 16'h1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  16'(rom_addr), 16'h000);
    chk("arst_oe",    16'(data_oe), 16'h0);
    chk("arst_exp",   16'(expansion_active), 16'h0);
    chk("arst_fetch", 16'(rom_fetch), 16'h0);
    release_all();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    start(16'hC401, 1'b1, 1'b1);
    tick(5);
    chk("post_oe",   16'(data_oe), 16'h1);
    chk("post_addr", 16'(rom_addr), 16'h001);
    release_all();
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
